// File: rtl/xbar_arbiter.sv
// Per-slave round-robin arbiter and route controller for a 2x2 crossbar.
// Optional watchdog release is enabled by defining XBAR_ARB_TIMEOUT_EN.
module xbar_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int SEL_BIT = 31,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mst_req,
  input  logic [ADDR_W-1:0] mst_addr [2],
  input  logic [1:0]        mst_done,
  output logic [1:0]        mst_gnt,
  output logic [1:0]        mst_route,
  output logic [1:0]        slv_en,
  output logic [1:0]        slv_sel,
  output logic [1:0]        timeout_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t     state_r [2];
  logic [1:0] owner_r;
  logic [1:0] ptr_r;
  logic [1:0] gnt_r;
  logic [1:0] route_r;
  logic [1:0] en_r;
  logic [1:0] sel_r;
  logic [1:0] terr_r;

  logic [1:0] tgt_s;
  logic [1:0] cand_s [2];
  logic [1:0] grant_s;
  logic [1:0] winner_s;
  logic [1:0] release_s;
  logic [1:0] expire_s;
  logic       unused_addr_s;

  // Only SEL_BIT of each address steers; the remaining bits belong to the datapath.
  assign unused_addr_s = ^{mst_addr[0], mst_addr[1]};

  // Candidate selection, round-robin winner and release detection per slave.
  always_comb begin
    tgt_s     = 2'b00;
    grant_s   = 2'b00;
    winner_s  = 2'b00;
    release_s = 2'b00;
    cand_s[0] = 2'b00;
    cand_s[1] = 2'b00;
    for (int m = 0; m < 2; m++) begin
      tgt_s[m] = mst_addr[m][SEL_BIT];
    end
    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m < 2; m++) begin
        cand_s[s][m] = mst_req[m] & (tgt_s[m] == 1'(s)) & ~gnt_r[m];
      end
      grant_s[s] = (state_r[s] == IDLE) & (|cand_s[s]);
      if (&cand_s[s]) begin
        winner_s[s] = ptr_r[s];
      end else if (cand_s[s][1]) begin
        winner_s[s] = 1'b1;
      end else begin
        winner_s[s] = 1'b0;
      end
      release_s[s] = (state_r[s] == OWNED) &
                     (mst_done[owner_r[s]] | ~mst_req[owner_r[s]]);
    end
  end

`ifdef XBAR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_r [2];

  // Watchdog expiry: the owner has sat on the slave for TIMEOUT+1 cycles.
  always_comb begin
    expire_s = 2'b00;
    for (int s = 0; s < 2; s++) begin
      expire_s[s] = (state_r[s] == OWNED) & (cnt_r[s] == CNT_W'(TIMEOUT));
    end
  end

  // Per-slave ownership cycle counters, cleared on entry to OWNED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r[0] <= '0;
      cnt_r[1] <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (grant_s[s]) begin
          cnt_r[s] <= '0;
        end else if ((state_r[s] == OWNED) && !release_s[s] && !expire_s[s]) begin
          cnt_r[s] <= cnt_r[s] + CNT_W'(1);
        end else begin
          cnt_r[s] <= cnt_r[s];
        end
      end
    end
  end
`else
  logic [31:0] unused_timeout_s;

  assign unused_timeout_s = 32'(TIMEOUT);
  assign expire_s         = 2'b00;
`endif

  // Slave FSMs with registered grant, route and steering outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r[0] <= IDLE;
      state_r[1] <= IDLE;
      owner_r    <= 2'b00;
      ptr_r      <= 2'b00;
      gnt_r      <= 2'b00;
      route_r    <= 2'b00;
      en_r       <= 2'b00;
      sel_r      <= 2'b00;
      terr_r     <= 2'b00;
    end else begin
      terr_r <= 2'b00;
      for (int s = 0; s < 2; s++) begin
        case (state_r[s])
          IDLE: begin
            if (grant_s[s]) begin
              state_r[s]            <= OWNED;
              owner_r[s]            <= winner_s[s];
              en_r[s]               <= 1'b1;
              sel_r[s]              <= winner_s[s];
              gnt_r[winner_s[s]]    <= 1'b1;
              route_r[winner_s[s]]  <= 1'(s);
            end else begin
              state_r[s] <= IDLE;
            end
          end
          OWNED: begin
            // A normal release wins over a simultaneous watchdog expiry.
            if (release_s[s] || expire_s[s]) begin
              state_r[s]         <= IDLE;
              en_r[s]            <= 1'b0;
              gnt_r[owner_r[s]]  <= 1'b0;
              ptr_r[s]           <= ~owner_r[s];
              terr_r[s]          <= expire_s[s] & ~release_s[s];
            end else begin
              state_r[s] <= OWNED;
            end
          end
          default: begin
            state_r[s] <= IDLE;
            en_r[s]    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mst_gnt     = gnt_r;
  assign mst_route   = route_r;
  assign slv_en      = en_r;
  assign slv_sel     = sel_r;
  assign timeout_err = terr_r;

endmodule

// File: tb/tb_xbar_arbiter.sv
// Self-checking bench for xbar_arbiter: directed scenarios plus random traffic
// compared against a transaction-level ownership model.
module tb_xbar_arbiter;

  localparam int SEL = 31;
  localparam int TO  = 4;
`ifdef XBAR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] addr [2];
  logic [1:0]  done;
  logic [1:0]  mst_gnt, mst_route, slv_en, slv_sel, timeout_err;

  int checks = 0;
  int errors = 0;

  // Model: owner per slave (-1 = free), favoured master per slave, per-master grant/route.
  int       m_own [2];
  int       m_cnt [2];
  bit [1:0] m_ptr, m_gnt, m_route, m_en, m_sel, m_terr;

  xbar_arbiter #(.ADDR_W(32), .SEL_BIT(SEL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mst_req(req), .mst_addr(addr), .mst_done(done),
    .mst_gnt(mst_gnt), .mst_route(mst_route), .slv_en(slv_en), .slv_sel(slv_sel),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  wire [9:0] dut_vec = {mst_gnt, mst_route, slv_en, slv_sel, timeout_err};

  function automatic logic [9:0] model_vec();
    return {m_gnt, m_route, m_en, m_sel, m_terr};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_own[s] = -1;
      m_cnt[s] = 0;
    end
    m_ptr = 2'b00; m_gnt = 2'b00; m_route = 2'b00;
    m_en = 2'b00;  m_sel = 2'b00; m_terr = 2'b00;
  endtask

  // Apply one clock edge of the ownership rules to the model.
  task automatic model_step();
    bit [1:0] g_old;
    g_old  = m_gnt;
    m_terr = 2'b00;
    for (int s = 0; s < 2; s++) begin
      if (m_own[s] < 0) begin
        int n = 0;
        int w = 0;
        for (int m = 0; m < 2; m++) begin
          if (req[m] && int'(addr[m][SEL]) == s && !g_old[m]) begin
            n++;
            w = m;
          end
        end
        if (n == 2) w = int'(m_ptr[s]);
        if (n > 0) begin
          m_own[s] = w; m_gnt[w] = 1'b1; m_route[w] = 1'(s);
          m_sel[s] = 1'(w); m_en[s] = 1'b1; m_cnt[s] = 0;
        end
      end else begin
        int  o = m_own[s];
        bit  rel = 1'b0;
        if (done[o] || !req[o]) rel = 1'b1;
        else if (TO_EN && m_cnt[s] == TO) begin
          rel = 1'b1;
          m_terr[s] = 1'b1;
        end else m_cnt[s]++;
        if (rel) begin
          m_own[s] = -1; m_en[s] = 1'b0; m_gnt[o] = 1'b0; m_ptr[s] = (o == 0);
        end
      end
    end
  endtask

  task automatic tick();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 2'b00; done = 2'b00;
    addr[0] = 32'h0; addr[1] = 32'h0;
    model_reset();
    #7;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00; done = 2'b00;
    addr[0] = 32'h0; addr[1] = 32'h0;
    model_reset();
    tick(); tick();
    checks++;
    if (dut_vec !== 10'b0) begin
      errors++; $display("FAIL reset_idle: got %b want %b", dut_vec, 10'b0);
    end
    #3 rst_n = 1'b1;
    req = 2'b01;
    tick();
    checks++;
    if (mst_gnt !== 2'b01 || dut_vec !== model_vec()) begin
      errors++; $display("FAIL reset_pregrant: got %b want %b", dut_vec, model_vec());
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 10'b0) begin
      errors++; $display("FAIL reset_async: got %b want %b", dut_vec, 10'b0);
    end
    #2;
    req = 2'b11; addr[0] = 32'h8000_0000; addr[1] = 32'h8000_0004;
    rst_n = 1'b1;
    tick();
    checks++;
    if (mst_gnt !== 2'b01 || slv_en !== 2'b10 || slv_sel[1] !== 1'b0 ||
        dut_vec !== model_vec()) begin
      errors++; $display("FAIL reset_ptr0: got %b want %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_disjoint();
    do_reset();
    tick();
    addr[0] = 32'h0000_0010; addr[1] = 32'h8000_0010; req = 2'b11;
    tick();
    checks++;
    if (mst_gnt !== 2'b11 || slv_sel !== 2'b10 || mst_route !== 2'b10 ||
        dut_vec !== model_vec()) begin
      errors++; $display("FAIL disjoint: got %b want %b", dut_vec, model_vec());
    end
    done = 2'b11; req = 2'b00;
    tick();
    done = 2'b00;
    checks++;
    if (mst_gnt !== 2'b00 || dut_vec !== model_vec()) begin
      errors++; $display("FAIL disjoint_release: got %b want %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_contention();
    do_reset();
    addr[0] = 32'h0000_0100; addr[1] = 32'h0000_0200; req = 2'b11;
    tick();
    checks++;
    if (mst_gnt !== 2'b01 || slv_sel[0] !== 1'b0) begin
      errors++; $display("FAIL contention_first: got gnt=%b sel=%b want gnt=01 sel0=0", mst_gnt, slv_sel);
    end
    for (int k = 0; k < 4; k++) begin
      int own = k % 2;
      done[own] = 1'b1;
      tick();
      done = 2'b00;
      checks++;
      if (mst_gnt !== 2'b00 || slv_en !== 2'b00) begin
        errors++; $display("FAIL contention_gap%0d: got gnt=%b en=%b want 00", k, mst_gnt, slv_en);
      end
      tick();
      checks++;
      if (mst_gnt !== (2'b01 << (1 - own)) || slv_sel[0] !== 1'(1 - own) ||
          dut_vec !== model_vec()) begin
        errors++; $display("FAIL contention_next%0d: got %b want %b", k, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    addr[1] = 32'h8000_0000; req = 2'b10;
    tick();
    done = 2'b01;
    tick();
    done = 2'b00;
    checks++;
    if (mst_gnt !== 2'b10 || slv_en !== 2'b10 || slv_sel[1] !== 1'b1) begin
      errors++; $display("FAIL stray_done: got %b want gnt=10 en=10", dut_vec);
    end
    req = 2'b00;
    tick();
    checks++;
    if (mst_gnt !== 2'b00 || slv_en !== 2'b00 || dut_vec !== model_vec()) begin
      errors++; $display("FAIL abort: got %b want %b", dut_vec, model_vec());
    end
    addr[0] = 32'h8000_0000; req = 2'b11;
    tick();
    checks++;
    if (mst_gnt !== 2'b01 || slv_sel[1] !== 1'b0) begin
      errors++; $display("FAIL abort_ptr: got gnt=%b sel=%b want gnt=01 sel1=0", mst_gnt, slv_sel);
    end
  endtask

  task automatic test_addr_change();
    do_reset();
    addr[0] = 32'h0000_0040; req = 2'b01;
    tick();
    addr[0] = 32'h8000_0040;
    tick();
    checks++;
    if (slv_en !== 2'b01 || slv_sel[0] !== 1'b0 || mst_route[0] !== 1'b0) begin
      errors++; $display("FAIL addr_flip: got %b want en=01 sel0=0 route0=0", dut_vec);
    end
    addr[1] = 32'h8000_0000; req = 2'b11;
    tick();
    checks++;
    if (mst_gnt !== 2'b11 || slv_sel[1] !== 1'b1 || mst_route !== 2'b10 ||
        dut_vec !== model_vec()) begin
      errors++; $display("FAIL addr_flip_other: got %b want %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    addr[0] = 32'h0; req = 2'b01;
    tick();
    for (int c = 2; c <= 5; c++) begin
      tick();
      checks++;
      if (mst_gnt !== 2'b01 || timeout_err !== 2'b00) begin
        errors++; $display("FAIL hold_cycle%0d: got gnt=%b terr=%b want gnt=01 terr=00", c, mst_gnt, timeout_err);
      end
    end
    tick();
    checks++;
    if (TO_EN) begin
      if (mst_gnt !== 2'b00 || timeout_err !== 2'b01) begin
        errors++; $display("FAIL timeout_fire: got gnt=%b terr=%b want gnt=00 terr=01", mst_gnt, timeout_err);
      end
    end else begin
      if (mst_gnt !== 2'b01 || timeout_err !== 2'b00) begin
        errors++; $display("FAIL no_timeout: got gnt=%b terr=%b want gnt=01 terr=00", mst_gnt, timeout_err);
      end
    end
    tick();
    checks++;
    if (timeout_err !== 2'b00 || dut_vec !== model_vec()) begin
      errors++; $display("FAIL timeout_pulse: got %b want %b", dut_vec, model_vec());
    end
    do_reset();
    req = 2'b01;
    for (int c = 0; c < 5; c++) tick();
    done = 2'b01;
    tick();
    done = 2'b00;
    checks++;
    if (mst_gnt !== 2'b00 || timeout_err !== 2'b00 || dut_vec !== model_vec()) begin
      errors++; $display("FAIL done_at_limit: got %b want %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      done = 2'b00;
      for (int m = 0; m < 2; m++) begin
        if (!req[m]) begin
          if ($urandom_range(0, 9) < 3) begin
            req[m] = 1'b1;
            addr[m] = {1'($urandom_range(0, 1)), 31'($urandom)};
          end
          if ($urandom_range(0, 19) == 0) done[m] = 1'b1;
        end else if (!m_gnt[m]) begin
          if ($urandom_range(0, 19) == 0) done[m] = 1'b1;
        end else begin
          case ($urandom_range(0, 9))
            0, 1: begin
              done[m] = 1'b1;
              req[m]  = 1'($urandom_range(0, 1));
              addr[m] = {1'($urandom_range(0, 1)), 31'($urandom)};
            end
            2: req[m] = 1'b0;
            3: addr[m][SEL] = ~addr[m][SEL];
            default: ;
          endcase
        end
      end
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d: got %b want %b", cyc, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_disjoint();
    test_contention();
    test_abort();
    test_addr_change();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
